// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cache_ctrl_pkg : shared state encoding and default sizing for cache_ctrl
// Revision       : 1.0
// ============================================================================
package cache_ctrl_pkg;

    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_CNT_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_MISS = 2'd1,
        S_REFILL  = 2'd2,
        S_WR_THRU = 2'd3
    } state_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_RD_MISS) || (s == S_WR_THRU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : up-counter with synchronous clear that sticks at all-ones
// Revision    : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// cache_ctrl : write-through / write-allocate cache miss controller with
//              access timeout and saturating performance counters
// Revision   : 1.0
// ============================================================================
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic             hit,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    output logic             refill_en,
    output logic             cache_we,
    output logic             err,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int               c_WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    state_t              r_state;
    logic [31:0]         r_addr;
    logic [c_WAIT_W-1:0] r_wait;
    logic                r_err;
    logic                r_mem_req;
    logic                r_mem_we;
    logic                r_refill;

    logic             w_idle_req;
    logic             w_tmo;
    logic             w_stall;
    logic             w_hit_inc;
    logic             w_miss_inc;
    logic             w_wr_inc;
    logic [CNT_W-1:0] w_hit_cnt;
    logic [CNT_W-1:0] w_miss_cnt;
    logic [CNT_W-1:0] w_wr_cnt;

    assign w_idle_req = (r_state == S_IDLE) && req_valid;
    assign w_tmo      = is_wait_state(r_state) && !mem_ack && (r_wait == c_WAIT_LAST);

    // Stall must rise in the same cycle a miss/store is seen, so it is decoded
    // from the current state and inputs rather than registered.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:    w_stall = req_valid && (req_we || !hit);
            S_RD_MISS: w_stall = !w_tmo;
            S_WR_THRU: w_stall = !mem_ack && !w_tmo;
            default:   w_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wait    <= '0;
            r_err     <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_refill  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_refill <= 1'b0;
                    if (req_valid && (req_we || !hit)) begin
                        r_state   <= req_we ? S_WR_THRU : S_RD_MISS;
                        r_addr    <= req_addr;
                        r_wait    <= '0;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= req_we;
                    end
                end
                S_RD_MISS, S_WR_THRU: begin
                    if (mem_ack || w_tmo) begin
                        r_state   <= (mem_ack && (r_state == S_RD_MISS)) ? S_REFILL : S_IDLE;
                        r_refill  <= mem_ack && (r_state == S_RD_MISS);
                        r_err     <= r_err | w_tmo;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end else begin
                        r_wait <= r_wait + c_WAIT_W'(1);
                    end
                end
                S_REFILL: begin
                    r_state  <= S_IDLE;
                    r_refill <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_hit_inc  = rst_n && w_idle_req && !req_we && hit;
    assign w_miss_inc = rst_n && w_idle_req && !req_we && !hit;
    assign w_wr_inc   = rst_n && w_idle_req && req_we;

    sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .i_clr (!rst_n),
        .i_inc (w_hit_inc),
        .o_cnt (w_hit_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .i_clr (!rst_n),
        .i_inc (w_miss_inc),
        .o_cnt (w_miss_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .i_clr (!rst_n),
        .i_inc (w_wr_inc),
        .o_cnt (w_wr_cnt)
    );

    // Every output is forced low while reset is held, even before the first edge.
    assign stall     = rst_n && w_stall;
    assign mem_req   = rst_n && r_mem_req;
    assign mem_we    = rst_n && r_mem_we;
    assign mem_addr  = rst_n ? r_addr : 32'd0;
    assign refill_en = rst_n && r_refill;
    assign cache_we  = rst_n && (r_state == S_WR_THRU) && mem_ack;
    assign err       = rst_n && r_err;
    assign hit_cnt   = rst_n ? w_hit_cnt  : '0;
    assign miss_cnt  = rst_n ? w_miss_cnt : '0;
    assign wr_cnt    = rst_n ? w_wr_cnt   : '0;

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cache_ctrl : directed scoreboard bench for cache_ctrl (TIMEOUT=8, CNT_W=4)
// Revision      : 1.0
// ============================================================================
module tb_cache_ctrl;

    localparam logic [5:0] c_S  = 6'b100000;
    localparam logic [5:0] c_MR = 6'b010000;
    localparam logic [5:0] c_MW = 6'b001000;
    localparam logic [5:0] c_RE = 6'b000100;
    localparam logic [5:0] c_CW = 6'b000010;
    localparam logic [5:0] c_ER = 6'b000001;

    typedef struct {
        string       nm;
        logic [5:0]  flags;
        logic [31:0] addr;
        logic [3:0]  hc;
        logic [3:0]  mc;
        logic [3:0]  wc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic        hit;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        refill_en;
    logic        cache_we;
    logic        err;
    logic [3:0]  hit_cnt;
    logic [3:0]  miss_cnt;
    logic [3:0]  wr_cnt;

    exp_t q[$];
    exp_t m_e;
    logic [5:0] m_flags;
    int checks   = 0;
    int failures = 0;

    cache_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .hit       (hit),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .refill_en (refill_en),
        .cache_we  (cache_we),
        .err       (err),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .wr_cnt    (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are sampled mid-cycle and compared against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e     = q.pop_front();
            m_flags = {stall, mem_req, mem_we, refill_en, cache_we, err};
            checks++;
            if (m_flags !== m_e.flags || mem_addr !== m_e.addr || hit_cnt !== m_e.hc ||
                miss_cnt !== m_e.mc || wr_cnt !== m_e.wc) begin
                failures++;
                $display("FAIL %s: got flags(stall,mreq,mwe,refill,cwe,err)=%b addr=%h hit=%0d miss=%0d wr=%0d, expected flags=%b addr=%h hit=%0d miss=%0d wr=%0d",
                         m_e.nm, m_flags, mem_addr, hit_cnt, miss_cnt, wr_cnt,
                         m_e.flags, m_e.addr, m_e.hc, m_e.mc, m_e.wc);
            end
        end
    end

    task automatic step(input string nm, input logic v, input logic we, input logic [31:0] a,
                        input logic h, input logic ack, input logic rn, input logic [5:0] ef,
                        input logic [31:0] ea, input int hc, input int mc, input int wc);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        hit       = h;
        mem_ack   = ack;
        rst_n     = rn;
        e.nm    = nm;
        e.flags = ef;
        e.addr  = ea;
        e.hc    = 4'(hc);
        e.mc    = 4'(mc);
        e.wc    = 4'(wc);
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; hit = 1'b0; mem_ack = 1'b0;

        step("rst_0",        0, 0, 32'h0,   0, 0, 0, 6'b0, 32'h0, 0, 0, 0);
        step("rst_1",        0, 0, 32'h0,   0, 0, 0, 6'b0, 32'h0, 0, 0, 0);

        step("hit_load",     1, 0, 32'h100, 1, 0, 1, 6'b0, 32'h0, 0, 0, 0);
        step("hit_cnt",      0, 0, 32'h0,   0, 0, 1, 6'b0, 32'h0, 1, 0, 0);

        step("miss_issue",   1, 0, 32'h204, 0, 0, 1, c_S,        32'h0,   1, 0, 0);
        step("rd_wait1",     1, 0, 32'h204, 0, 0, 1, c_S | c_MR, 32'h204, 1, 1, 0);
        step("rd_wait2",     1, 0, 32'h204, 0, 0, 1, c_S | c_MR, 32'h204, 1, 1, 0);
        step("rd_ack",       1, 0, 32'h204, 0, 1, 1, c_S | c_MR, 32'h204, 1, 1, 0);
        step("refill",       0, 0, 32'h0,   0, 1, 1, c_RE,       32'h204, 1, 1, 0);
        step("after_refill", 0, 0, 32'h0,   0, 0, 1, 6'b0,       32'h204, 1, 1, 0);

        step("st_issue",     1, 1, 32'h30,  1, 0, 1, c_S,                32'h204, 1, 1, 0);
        step("st_ack",       1, 1, 32'h30,  1, 1, 1, c_MR | c_MW | c_CW, 32'h30,  1, 1, 1);
        step("st_idle_ack",  0, 0, 32'h0,   0, 1, 1, 6'b0,               32'h30,  1, 1, 1);
        step("st2_issue",    1, 1, 32'h44,  0, 0, 1, c_S,                32'h30,  1, 1, 1);
        step("st2_wait",     1, 1, 32'h44,  0, 0, 1, c_S | c_MR | c_MW,  32'h44,  1, 1, 2);
        step("st2_ack",      1, 1, 32'h44,  0, 1, 1, c_MR | c_MW | c_CW, 32'h44,  1, 1, 2);
        step("st2_idle",     0, 0, 32'h0,   0, 0, 1, 6'b0,               32'h44,  1, 1, 2);

        step("to_issue",     1, 0, 32'h300, 0, 0, 1, c_S, 32'h44, 1, 1, 2);
        for (int i = 1; i <= 7; i++)
            step("to_wait",  1, 0, 32'h300, 0, 0, 1, c_S | c_MR, 32'h300, 1, 2, 2);
        step("to_abort",     1, 0, 32'h300, 0, 0, 1, c_MR, 32'h300, 1, 2, 2);
        step("to_hit",       1, 0, 32'h100, 1, 0, 1, c_ER, 32'h300, 1, 2, 2);
        step("to_idle",      0, 0, 32'h0,   0, 0, 1, c_ER, 32'h300, 2, 2, 2);

        step("rm_issue",     1, 0, 32'h400, 0, 0, 1, c_S | c_ER,        32'h300, 2, 2, 2);
        step("rm_wait1",     1, 0, 32'h400, 0, 0, 1, c_S | c_MR | c_ER, 32'h400, 2, 3, 2);
        step("rm_rst",       1, 0, 32'h400, 0, 0, 0, 6'b0, 32'h0, 0, 0, 0);
        step("rm_late_ack",  0, 0, 32'h0,   0, 1, 1, 6'b0, 32'h0, 0, 0, 0);
        step("rm_idle",      0, 0, 32'h0,   0, 0, 1, 6'b0, 32'h0, 0, 0, 0);

        for (int k = 0; k <= 16; k++)
            step("sat_load", 1, 0, 32'h100, 1, 0, 1, 6'b0, 32'h0, (k > 15) ? 15 : k, 0, 0);
        step("sat_hold",     0, 0, 32'h0,   0, 0, 1, 6'b0, 32'h0, 15, 0, 0);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
